// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the multicycle MIPS controller.
// Holds the FSM state encoding, the decoded opcode/funct values and the
// datapath select/ALU codes. Imported by multicycle_controller and
// mc_alu_funct_dec.
package mc_pkg;

    // 4-bit state encoding; 13..15 are unused and recover to FETCH.
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_JUMP    = 4'd10,
        S_JAL     = 4'd11,
        S_ADDIWB  = 4'd12
    } state_t;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;

    // R-type functs (IR[5:0])
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_JR  = 6'b001000;

    // ALU control
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    // PC source
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_A      = 2'b11;

    // ALU B source
    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // Register file write address select
    localparam logic [1:0] RD_RT  = 2'b00;
    localparam logic [1:0] RD_RD  = 2'b01;
    localparam logic [1:0] RD_R31 = 2'b10;

    // Register file write data select
    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

endpackage

// File: rtl/mc_alu_funct_dec.sv
// mc_alu_funct_dec: combinational R-type funct decoder.
// Ports:
//   funct      in  6  IR[5:0]
//   alucontrol out 4  ALU operation for the funct (ADD when not arithmetic)
//   is_jr      out 1  funct is jr
//   bad_funct  out 1  funct is not one of the supported R-type functs
module mc_alu_funct_dec
    import mc_pkg::*;
(
    input  logic [5:0] funct,
    output logic [3:0] alucontrol,
    output logic       is_jr,
    output logic       bad_funct
);

    always_comb begin
        alucontrol = ALU_ADD;
        is_jr      = 1'b0;
        bad_funct  = 1'b0;
        case (funct)
            FN_ADD:  alucontrol = ALU_ADD;
            FN_SUB:  alucontrol = ALU_SUB;
            FN_AND:  alucontrol = ALU_AND;
            FN_OR:   alucontrol = ALU_OR;
            FN_SLT:  alucontrol = ALU_SLT;
            FN_JR:   is_jr      = 1'b1;
            default: bad_funct  = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore FSM sequencing the multicycle MIPS datapath
// (shared memory, single ALU, IR/MDR/A/B/ALUOut holding registers).
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   op, funct               IR[31:26], IR[5:0]
//   zero                    ALU zero flag (branch qualification)
//   mem_ready               memory completes the access this cycle
//   pcwrite, irwrite,
//   regwrite                register load enables
//   memread, memwrite       memory requests
//   iord, regdst, memtoreg,
//   alusrca, alusrcb,
//   pcsrc, alucontrol       datapath selects / ALU operation
//   illegal                 one-cycle pulse on an undecodable op or funct
//   state_o                 current state (debug)
//   instret, cycles         performance counters (only with MC_PERF_CNT_EN)
//
// Memory handshake: a request (memread or memwrite) is held steady, with its
// address select, until a cycle in which mem_ready is high; that cycle
// completes the access and the FSM moves on at the next clock edge. With
// WAIT_EN_DEFAULT = 0 mem_ready is ignored and every access takes one cycle.
//
// Optional feature macro: MC_PERF_CNT_EN adds the instret/cycles counters.
module multicycle_controller
    import mc_pkg::*;
#(
    parameter logic WAIT_EN_DEFAULT = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [5:0]  op,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pcwrite,
    output logic        iord,
    output logic        memread,
    output logic        memwrite,
    output logic        irwrite,
    output logic [1:0]  regdst,
    output logic [1:0]  memtoreg,
    output logic        regwrite,
    output logic        alusrca,
    output logic [1:0]  alusrcb,
    output logic [3:0]  alucontrol,
    output logic [1:0]  pcsrc,
    output logic        illegal,
`ifdef MC_PERF_CNT_EN
    output logic [31:0] instret,
    output logic [31:0] cycles,
`endif
    output logic [3:0]  state_o
);

    state_t     state_q, state_d;
    logic       ready;
    logic [3:0] dec_alu;
    logic       dec_jr;
    logic       dec_bad;

    assign ready   = WAIT_EN_DEFAULT ? mem_ready : 1'b1;
    assign state_o = state_q;

    mc_alu_funct_dec u_funct_dec (
        .funct      (funct),
        .alucontrol (dec_alu),
        .is_jr      (dec_jr),
        .bad_funct  (dec_bad)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_FETCH;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        pcwrite    = 1'b0;
        iord       = 1'b0;
        memread    = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regdst     = RD_RT;
        memtoreg   = M2R_ALUOUT;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = SRCB_B;
        alucontrol = ALU_ADD;
        pcsrc      = PCSRC_ALU;
        illegal    = 1'b0;

        case (state_q)
            S_FETCH: begin
                // PC+4 goes straight into the PC in the same cycle the
                // instruction word lands in IR.
                memread = 1'b1;
                alusrcb = SRCB_FOUR;
                pcsrc   = PCSRC_ALU;
                irwrite = ready;
                pcwrite = ready;
                if (ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                // Speculative branch target into ALUOut.
                alusrcb = SRCB_IMM_SH;
                case (op)
                    OP_LW, OP_SW:   state_d = S_MEMADR;
                    OP_R:           state_d = S_RTYPEEX;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_ADDI:        state_d = S_ADDIEX;
                    OP_J:           state_d = S_JUMP;
                    OP_JAL:         state_d = S_JAL;
                    default: begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
                state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                iord    = 1'b1;
                memread = 1'b1;
                if (ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                regdst   = RD_RT;
                memtoreg = M2R_MDR;
                regwrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
                if (ready) state_d = S_FETCH;
            end
            S_RTYPEEX: begin
                alusrca    = 1'b1;
                alusrcb    = SRCB_B;
                alucontrol = dec_alu;
                if (dec_jr) begin
                    pcsrc   = PCSRC_A;
                    pcwrite = 1'b1;
                    state_d = S_FETCH;
                end else if (dec_bad) begin
                    illegal = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_ALUWB;
                end
            end
            S_ALUWB: begin
                regdst   = RD_RD;
                memtoreg = M2R_ALUOUT;
                regwrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                alusrca    = 1'b1;
                alusrcb    = SRCB_B;
                alucontrol = ALU_SUB;
                pcsrc      = PCSRC_ALUOUT;
                pcwrite    = (op == OP_BNE) ? ~zero : zero;
                state_d    = S_FETCH;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                regdst   = RD_RT;
                memtoreg = M2R_ALUOUT;
                regwrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_JUMP: begin
                pcsrc   = PCSRC_JUMP;
                pcwrite = 1'b1;
                state_d = S_FETCH;
            end
            S_JAL: begin
                // PC already holds PC+4, which is the link value.
                regdst   = RD_R31;
                memtoreg = M2R_PC;
                regwrite = 1'b1;
                pcsrc    = PCSRC_JUMP;
                pcwrite  = 1'b1;
                state_d  = S_FETCH;
            end
            default: begin
                illegal = 1'b1;
                state_d = S_FETCH;
            end
        endcase

        // Reset overrides the FETCH decode immediately so an in-flight
        // memory request drops without waiting for a clock edge.
        if (!reset_n) begin
            pcwrite    = 1'b0;
            iord       = 1'b0;
            memread    = 1'b0;
            memwrite   = 1'b0;
            irwrite    = 1'b0;
            regdst     = RD_RT;
            memtoreg   = M2R_ALUOUT;
            regwrite   = 1'b0;
            alusrca    = 1'b0;
            alusrcb    = SRCB_B;
            alucontrol = ALU_ADD;
            pcsrc      = PCSRC_ALU;
            illegal    = 1'b0;
        end
    end

`ifdef MC_PERF_CNT_EN
    // An instruction retires when control returns to FETCH without an
    // illegal abort.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycles  <= '0;
            instret <= '0;
        end else begin
            cycles <= cycles + 32'd1;
            if (state_q != S_FETCH && state_d == S_FETCH && !illegal)
                instret <= instret + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: self-checking bench for multicycle_controller.
module tb_multicycle_controller;

    localparam logic [5:0] T_R    = 6'b000000;
    localparam logic [5:0] T_LW   = 6'b100011;
    localparam logic [5:0] T_SW   = 6'b101011;
    localparam logic [5:0] T_BEQ  = 6'b000100;
    localparam logic [5:0] T_BNE  = 6'b000101;
    localparam logic [5:0] T_ADDI = 6'b001000;
    localparam logic [5:0] T_J    = 6'b000010;
    localparam logic [5:0] T_JAL  = 6'b000011;

    // Expected per-instruction observations.
    typedef struct {
        logic [5:0] op;
        logic [5:0] funct;
        logic       zero;
        int         fw;      // FETCH wait cycles
        int         mw;      // data-memory wait cycles
        int         cycles;  // clock edges until back in FETCH
        int         rw;      // regwrite cycles
        logic [1:0] regdst;
        logic [1:0] m2r;
        int         mwc;     // memwrite cycles
        int         mrc;     // memread cycles
        int         pw;      // pcwrite cycles
        logic [1:0] pcsrc;   // pcsrc on the non-fetch pcwrite
        logic [3:0] alu;     // alucontrol in the first post-decode state
        logic       alu_v;
        int         ill;     // illegal cycles
        int         rwpw;    // cycles with regwrite and pcwrite together
    } vec_t;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic [5:0]  op, funct;
    logic        zero, mem_ready;
    logic        pcwrite, iord, memread, memwrite, irwrite, regwrite, alusrca, illegal;
    logic [1:0]  regdst, memtoreg, alusrcb, pcsrc;
    logic [3:0]  alucontrol, state_o;
`ifdef MC_PERF_CNT_EN
    logic [31:0] instret, cycles;
`endif

    multicycle_controller dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pcwrite    (pcwrite),
        .iord       (iord),
        .memread    (memread),
        .memwrite   (memwrite),
        .irwrite    (irwrite),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .regwrite   (regwrite),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .alucontrol (alucontrol),
        .pcsrc      (pcsrc),
        .illegal    (illegal),
`ifdef MC_PERF_CNT_EN
        .instret    (instret),
        .cycles     (cycles),
`endif
        .state_o    (state_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // scoreboard: expected state trace
    logic [3:0] exp_q[$];

    // observations from the last instruction
    int         obs_cycles, obs_rw, obs_mw, obs_mw_bad, obs_mr, obs_ir, obs_pw;
    int         obs_ill, obs_rwpw, obs_fetch_bad;
    logic [1:0] obs_regdst, obs_m2r, obs_pcsrc, obs_dec_srcb;
    logic [3:0] obs_alu;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one instruction from FETCH back to FETCH, collecting observations.
    task automatic run_instr(input logic [5:0] i_op, input logic [5:0] i_funct,
                             input logic i_zero, input int fw, input int mw);
        int         c;
        int         trace_len;
        logic       done;
        logic [3:0] s_now;
        logic [3:0] e;
        obs_rw = 0; obs_mw = 0; obs_mw_bad = 0; obs_mr = 0; obs_ir = 0; obs_pw = 0;
        obs_ill = 0; obs_rwpw = 0; obs_fetch_bad = 0;
        obs_regdst = 2'b11; obs_m2r = 2'b11; obs_pcsrc = 2'b00;
        obs_alu = 4'hF; obs_dec_srcb = 2'b00;
        op = i_op; funct = i_funct; zero = i_zero;
        trace_len = exp_q.size();
        done = 1'b0;
        c = 0;
        while (!done && c < 60) begin
            mem_ready = ((c < fw) || (c >= fw + 3 && c < fw + 3 + mw)) ? 1'b0 : 1'b1;
            @(negedge clk);
            s_now = state_o;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("trace_state", {28'd0, s_now}, {28'd0, e});
            end
            if (regwrite) begin
                obs_rw++;
                obs_regdst = regdst;
                obs_m2r = memtoreg;
                if (pcwrite) obs_rwpw++;
            end
            if (memwrite) begin
                obs_mw++;
                if (!iord) obs_mw_bad++;
            end
            if (memread) obs_mr++;
            if (irwrite) obs_ir++;
            if (pcwrite) begin
                obs_pw++;
                if (s_now != 4'd0) obs_pcsrc = pcsrc;
            end
            if (illegal) obs_ill++;
            if (c == fw + 1) obs_dec_srcb = alusrcb;
            if (c == fw + 2) obs_alu = alucontrol;
            if (s_now == 4'd0 && (memread !== 1'b1 || alusrcb !== 2'b01 || iord !== 1'b0 ||
                                  irwrite !== mem_ready || pcwrite !== mem_ready))
                obs_fetch_bad++;
            @(posedge clk);
            #1;
            c++;
            done = (state_o == 4'd0 && s_now != 4'd0);
        end
        obs_cycles = c;
        check("no_timeout", {31'd0, done}, 32'd1);
        if (trace_len > 0) check("trace_len", obs_cycles, trace_len);
        exp_q.delete();
    endtask

    task automatic compare_obs(input vec_t v);
        check("cycles", obs_cycles, v.cycles);
        check("regwrite_cnt", obs_rw, v.rw);
        if (v.rw > 0) begin
            check("regdst", {30'd0, obs_regdst}, {30'd0, v.regdst});
            check("memtoreg", {30'd0, obs_m2r}, {30'd0, v.m2r});
        end
        check("memwrite_cnt", obs_mw, v.mwc);
        check("memwrite_iord", obs_mw_bad, 0);
        check("memread_cnt", obs_mr, v.mrc);
        check("irwrite_cnt", obs_ir, 1);
        check("pcwrite_cnt", obs_pw, v.pw);
        if (v.pw > 1) check("pcsrc", {30'd0, obs_pcsrc}, {30'd0, v.pcsrc});
        if (v.alu_v) check("alucontrol", {28'd0, obs_alu}, {28'd0, v.alu});
        check("illegal_cnt", obs_ill, v.ill);
        check("regwrite_with_pcwrite", obs_rwpw, v.rwpw);
        check("fetch_outputs", obs_fetch_bad, 0);
        check("decode_alusrcb", {30'd0, obs_dec_srcb}, 32'd3);
    endtask

    // Reference model: derives the phase trace and the expected totals from
    // the instruction class.
    task automatic model(input logic [5:0] m_op, input logic [5:0] m_funct,
                         input logic m_zero, input int fw, input int mw, output vec_t v);
        logic taken;
        v = '{m_op, m_funct, m_zero, fw, mw, 0, 0, 2'b00, 2'b00, 0, fw + 1, 1, 2'b00,
              4'b0010, 1'b0, 0, 0};
        for (int i = 0; i <= fw; i++) exp_q.push_back(4'd0);
        exp_q.push_back(4'd1);
        if (m_op == T_LW) begin
            exp_q.push_back(4'd2);
            for (int i = 0; i <= mw; i++) exp_q.push_back(4'd3);
            exp_q.push_back(4'd4);
            v.rw = 1; v.regdst = 2'b00; v.m2r = 2'b01;
            v.mrc = fw + 1 + mw + 1; v.alu_v = 1'b1;
        end else if (m_op == T_SW) begin
            exp_q.push_back(4'd2);
            for (int i = 0; i <= mw; i++) exp_q.push_back(4'd5);
            v.mwc = mw + 1; v.alu_v = 1'b1;
        end else if (m_op == T_R) begin
            exp_q.push_back(4'd6);
            v.alu_v = 1'b1;
            case (m_funct)
                6'b100000: v.alu = 4'b0010;
                6'b100010: v.alu = 4'b0110;
                6'b100100: v.alu = 4'b0000;
                6'b100101: v.alu = 4'b0001;
                6'b101010: v.alu = 4'b0111;
                6'b001000: begin v.alu_v = 1'b0; v.pw = 2; v.pcsrc = 2'b11; end
                default:   begin v.alu_v = 1'b0; v.ill = 1; end
            endcase
            if (v.alu_v) begin
                exp_q.push_back(4'd7);
                v.rw = 1; v.regdst = 2'b01; v.m2r = 2'b00;
            end
        end else if (m_op == T_BEQ || m_op == T_BNE) begin
            exp_q.push_back(4'd8);
            v.alu = 4'b0110; v.alu_v = 1'b1;
            taken = (m_op == T_BEQ) ? m_zero : !m_zero;
            if (taken) begin v.pw = 2; v.pcsrc = 2'b01; end
        end else if (m_op == T_ADDI) begin
            exp_q.push_back(4'd9);
            exp_q.push_back(4'd12);
            v.rw = 1; v.alu_v = 1'b1;
        end else if (m_op == T_J) begin
            exp_q.push_back(4'd10);
            v.pw = 2; v.pcsrc = 2'b10;
        end else if (m_op == T_JAL) begin
            exp_q.push_back(4'd11);
            v.rw = 1; v.regdst = 2'b10; v.m2r = 2'b10;
            v.pw = 2; v.pcsrc = 2'b10; v.rwpw = 1;
        end else begin
            v.ill = 1;
        end
        v.cycles = exp_q.size();
    endtask

    vec_t tbl[18];

    initial begin
        // watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        logic [5:0] r_op, r_fn;
        logic [5:0] op_pool[8];
        logic [5:0] fn_pool[6];

        // order: op, funct, zero, fw, mw, cycles, rw, regdst, m2r, mwc, mrc, pw,
        //        pcsrc, alu, alu_v, ill, rwpw
        tbl[0]  = '{T_R, 6'b100000, 1'b0, 0, 0, 4, 1, 2'b01, 2'b00, 0, 1, 1, 2'b00, 4'b0010, 1'b1, 0, 0};
        tbl[1]  = '{T_R, 6'b100010, 1'b0, 0, 0, 4, 1, 2'b01, 2'b00, 0, 1, 1, 2'b00, 4'b0110, 1'b1, 0, 0};
        tbl[2]  = '{T_R, 6'b100100, 1'b0, 0, 0, 4, 1, 2'b01, 2'b00, 0, 1, 1, 2'b00, 4'b0000, 1'b1, 0, 0};
        tbl[3]  = '{T_R, 6'b100101, 1'b0, 0, 0, 4, 1, 2'b01, 2'b00, 0, 1, 1, 2'b00, 4'b0001, 1'b1, 0, 0};
        tbl[4]  = '{T_R, 6'b101010, 1'b0, 0, 0, 4, 1, 2'b01, 2'b00, 0, 1, 1, 2'b00, 4'b0111, 1'b1, 0, 0};
        tbl[5]  = '{T_R, 6'b111111, 1'b0, 0, 0, 3, 0, 2'b00, 2'b00, 0, 1, 1, 2'b00, 4'b0010, 1'b0, 1, 0};
        tbl[6]  = '{T_R, 6'b001000, 1'b0, 0, 0, 3, 0, 2'b00, 2'b00, 0, 1, 2, 2'b11, 4'b0010, 1'b0, 0, 0};
        tbl[7]  = '{T_BEQ, 6'd0, 1'b1, 0, 0, 3, 0, 2'b00, 2'b00, 0, 1, 2, 2'b01, 4'b0110, 1'b1, 0, 0};
        tbl[8]  = '{T_BNE, 6'd0, 1'b1, 0, 0, 3, 0, 2'b00, 2'b00, 0, 1, 1, 2'b00, 4'b0110, 1'b1, 0, 0};
        tbl[9]  = '{T_BEQ, 6'd0, 1'b0, 0, 0, 3, 0, 2'b00, 2'b00, 0, 1, 1, 2'b00, 4'b0110, 1'b1, 0, 0};
        tbl[10] = '{T_BNE, 6'd0, 1'b0, 0, 0, 3, 0, 2'b00, 2'b00, 0, 1, 2, 2'b01, 4'b0110, 1'b1, 0, 0};
        tbl[11] = '{T_ADDI, 6'd0, 1'b0, 0, 0, 4, 1, 2'b00, 2'b00, 0, 1, 1, 2'b00, 4'b0010, 1'b1, 0, 0};
        tbl[12] = '{T_J, 6'd0, 1'b0, 0, 0, 3, 0, 2'b00, 2'b00, 0, 1, 2, 2'b10, 4'b0010, 1'b0, 0, 0};
        tbl[13] = '{T_JAL, 6'd0, 1'b0, 0, 0, 3, 1, 2'b10, 2'b10, 0, 1, 2, 2'b10, 4'b0010, 1'b0, 0, 1};
        tbl[14] = '{6'b111111, 6'd0, 1'b0, 0, 0, 2, 0, 2'b00, 2'b00, 0, 1, 1, 2'b00, 4'b0010, 1'b0, 1, 0};
        tbl[15] = '{T_SW, 6'd0, 1'b0, 0, 0, 4, 0, 2'b00, 2'b00, 1, 1, 1, 2'b00, 4'b0010, 1'b1, 0, 0};
        tbl[16] = '{T_SW, 6'd0, 1'b0, 1, 2, 7, 0, 2'b00, 2'b00, 3, 2, 1, 2'b00, 4'b0010, 1'b1, 0, 0};
        tbl[17] = '{T_LW, 6'd0, 1'b0, 0, 0, 5, 1, 2'b00, 2'b01, 0, 2, 1, 2'b00, 4'b0010, 1'b1, 0, 0};

        op_pool = '{T_R, T_LW, T_SW, T_BEQ, T_BNE, T_ADDI, T_J, T_JAL};
        fn_pool = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b001000};

        // reset state
        reset_n = 1'b0; op = T_LW; funct = 6'd0; zero = 1'b0; mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_state", {28'd0, state_o}, 32'd0);
        check("rst_memread", {31'd0, memread}, 32'd0);
        check("rst_irwrite", {31'd0, irwrite}, 32'd0);
        check("rst_pcwrite", {31'd0, pcwrite}, 32'd0);
        check("rst_alusrcb", {30'd0, alusrcb}, 32'd0);
        check("rst_alucontrol", {28'd0, alucontrol}, 32'd2);
        check("rst_illegal", {31'd0, illegal}, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // table-driven vectors
        for (int i = 0; i < 18; i++) begin
            run_instr(tbl[i].op, tbl[i].funct, tbl[i].zero, tbl[i].fw, tbl[i].mw);
            compare_obs(tbl[i]);
        end

        // lw with 2 FETCH waits and 1 MEMRD wait: 0,0,0,1,2,3,3,4 then FETCH
        exp_q = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd4};
        run_instr(T_LW, 6'd0, 1'b0, 2, 1);
        check("lw_wait_regwrite", obs_rw, 1);
        check("lw_wait_memtoreg", {30'd0, obs_m2r}, 32'd1);
        check("lw_wait_memread", obs_mr, 5);

        // randomized instructions against the reference model
        for (int n = 0; n < 150; n++) begin
            int fw, mw, k;
            logic z;
            k = $urandom_range(0, 9);
            r_op = (k < 8) ? op_pool[k] : 6'($urandom_range(0, 63));
            k = $urandom_range(0, 7);
            r_fn = (k < 6) ? fn_pool[k] : 6'($urandom_range(0, 63));
            z = 1'($urandom_range(0, 1));
            fw = $urandom_range(0, 2);
            mw = $urandom_range(0, 2);
            model(r_op, r_fn, z, fw, mw, v);
            run_instr(r_op, r_fn, z, fw, mw);
            compare_obs(v);
        end

        // reset during a stalled store drops memwrite with no clock edge
        op = T_SW; funct = 6'd0; mem_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(negedge clk);
        check("memwr_state", {28'd0, state_o}, 32'd5);
        check("memwr_hold_we", {31'd0, memwrite}, 32'd1);
        @(posedge clk); #2;
        check("memwr_hold_we2", {31'd0, memwrite}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("async_rst_memwrite", {31'd0, memwrite}, 32'd0);
        check("async_rst_iord", {31'd0, iord}, 32'd0);
        check("async_rst_state", {28'd0, state_o}, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        check("post_rst_state", {28'd0, state_o}, 32'd0);
        model(T_J, 6'd0, 1'b0, 0, 0, v);
        run_instr(T_J, 6'd0, 1'b0, 0, 0);
        compare_obs(v);

`ifdef MC_PERF_CNT_EN
        reset_n = 1'b0;
        @(negedge clk);
        check("perf_rst_instret", instret, 32'd0);
        check("perf_rst_cycles", cycles, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        model(T_LW, 6'd0, 1'b0, 0, 0, v); run_instr(T_LW, 6'd0, 1'b0, 0, 0); compare_obs(v);
        model(T_SW, 6'd0, 1'b0, 0, 0, v); run_instr(T_SW, 6'd0, 1'b0, 0, 0); compare_obs(v);
        model(T_J, 6'd0, 1'b0, 0, 0, v);  run_instr(T_J, 6'd0, 1'b0, 0, 0);  compare_obs(v);
        check("perf_instret", instret, 32'd3);
        check("perf_cycles", cycles, 32'd12);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
